// File: rtl/main_mem_line_server.sv
// Memory-side responder for data-cache refill and writeback traffic.
// Serves whole-line reads and writes, each completing a fixed number of edges after acceptance.
module main_mem_line_server #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int MEM_ADDR_LEN  = 8,
    parameter int LATENCY       = 10
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rd_req,
    input  logic [31:0]                        rd_addr,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]   rd_line,
    output logic                               rd_gnt,
    input  logic                               wr_req,
    input  logic [31:0]                        wr_addr,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]   wr_line,
    output logic                               wr_gnt
);

    localparam int LINE_W = 32 * (2**LINE_ADDR_LEN);
    localparam int DEPTH  = 2**MEM_ADDR_LEN;
    localparam int LAT    = (LATENCY < 1) ? 1 : LATENCY;
    localparam int CNT_W  = (LAT < 2) ? 1 : $clog2(LAT + 1);
    localparam int IDX_LO = LINE_ADDR_LEN + 2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_WR,
        BUSY_RD,
        DONE
    } state_t;

    state_t                    state, state_n;
    logic [CNT_W-1:0]          cnt, cnt_n;
    logic [MEM_ADDR_LEN-1:0]   cap_idx, cap_idx_n;
    logic [LINE_W-1:0]         cap_line, cap_line_n;
    logic                      mem_we;
    logic                      rd_load;
    logic                      rd_gnt_n;
    logic                      wr_gnt_n;

    logic [LINE_W-1:0]         mem [DEPTH];

    // Byte offset and bits above the index are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_addr, wr_addr};

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        cap_idx_n  = cap_idx;
        cap_line_n = cap_line;
        mem_we     = 1'b0;
        rd_load    = 1'b0;
        rd_gnt_n   = 1'b0;
        wr_gnt_n   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    cap_idx_n  = wr_addr[IDX_LO +: MEM_ADDR_LEN];
                    cap_line_n = wr_line;
                    cnt_n      = CNT_W'(LAT);
                    state_n    = BUSY_WR;
                end else if (rd_req) begin
                    cap_idx_n  = rd_addr[IDX_LO +: MEM_ADDR_LEN];
                    cnt_n      = CNT_W'(LAT);
                    state_n    = BUSY_RD;
                end
            end
            BUSY_WR: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    mem_we   = 1'b1;
                    wr_gnt_n = 1'b1;
                    state_n  = DONE;
                end
            end
            BUSY_RD: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    rd_load  = 1'b1;
                    rd_gnt_n = 1'b1;
                    state_n  = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_gnt  <= 1'b0;
            wr_gnt  <= 1'b0;
            rd_line <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rd_gnt <= rd_gnt_n;
            wr_gnt <= wr_gnt_n;
            if (rd_load) begin
                rd_line <= mem[cap_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        cap_idx  <= cap_idx_n;
        cap_line <= cap_line_n;
    end

    // Reset on the completion edge drops the write; array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[cap_idx] <= cap_line;
        end
    end

endmodule
